jtag_packet_rx: RTL and testbench
=================================

// Module: jtag_packet_rx
// PURPOSE
//  Host->FPGA half of the JTAG user-chain link; the FPGA->host byte path is handled by the existing JTAG FIFO.
//  Lives entirely in the TCK domain behind BSCAN USER1. It shifts 9-bit DR words, keeps host bytes flagged valid,
//  de-frames them into checked packets (SOF, LEN, payload, checksum) and presents one packet on a flat bus.
//  Primary use: delivering 44-byte mining work units to the hashing core.
// PARAMETERS
//  MAX_LEN  44     maximum payload bytes per packet (pkt_data width = 8*MAX_LEN)
//  SOF      8'hA5  start-of-frame byte
// PORTS
//  jt_tck      in   1          TCK from BSCAN; all state on posedge
//  jt_reset    in   1          reset, asynchronous, active-high (BSCAN RESET)
//  jt_sel      in   1          user chain selected
//  jt_capture  in   1          Capture-DR
//  jt_shift    in   1          Shift-DR
//  jt_update   in   1          Update-DR
//  jt_tdi      in   1          serial data from host
//  pkt_ack     in   1          consumer accepts held packet (already synchronised to jt_tck by the consumer)
//  pkt_valid   out  1          a checked packet is held on pkt_data/pkt_len
//  pkt_len     out  8          payload byte count, 1..MAX_LEN
//  pkt_data    out  8*MAX_LEN  payload; byte i on [8i+7:8i]; bytes >= pkt_len are 0
//  err_csum    out  8          checksum-failure count, saturates at 255
//  err_len     out  8          bad-LEN count (0 or >MAX_LEN), saturates at 255
//  err_drop    out  8          bytes dropped while holding a packet, saturates at 255
//  busy        out  1          FSM is not in IDLE
// BEHAVIOUR
//  Reset (async, jt_reset=1): sr=0, FSM=IDLE; all outputs 0, including pkt_data, pkt_len and the error counters.
//  Shift register sr[8:0], all on posedge jt_tck, gated by jt_sel:
//   - capture -> sr=0
//   - shift   -> sr={jt_tdi,sr[8:1]} (LSB first; bit 8 is shifted in last)
//   - update  -> word=sr: sr[8]=1 means byte b=sr[7:0] is valid; sr[8]=0 is an idle word, ignored in every state
//  Byte event: sel&update&sr[8]. The FSM consumes it on that same posedge, so there is zero added latency.
//  Running sum S is 8-bit, wraps mod 256. A frame is good when LEN + payload + CSUM == 8'h00 (mod 256).
//  FSM states and transitions:
//   - IDLE:    b==SOF -> LEN. Any other byte is discarded silently.
//   - LEN:     b==0 or b>MAX_LEN -> err_len++, then IDLE.
//              Otherwise len=b, S=b, idx=0, clear buffer -> PAYLOAD.
//              A second SOF here is treated as LEN=0xA5 and obeys the same rule.
//   - PAYLOAD: buf[idx]=b, S+=b, idx++. On idx==len-1 -> CSUM.
//   - CSUM:    S+b==0 -> pkt_valid=1, pkt_len=len -> HOLD. Otherwise err_csum++ -> IDLE; the buffer is not presented.
//   - HOLD:    pkt_data/pkt_len stable while pkt_valid=1.
//              pkt_ack=1 -> pkt_valid=0, then IDLE on the next edge.
//              Any byte event in HOLD, including one on the ack edge, is dropped and err_drop++.
//  No timeout: a partially received frame waits indefinitely. Host recovery is a TAP reset (jt_reset) or completing the frame.
//  jt_reset mid-frame or in HOLD aborts at once. Packet contents are lost and counters clear.
//  Byte event and capture/shift cannot coincide (TAP states are exclusive); no priority rule is needed.
//  pkt_ack outside HOLD is ignored.
// STRUCTURE
//  jtag_proto_pkg: SOF, word-width constant (9), valid-flag bit index (8), FSM state enum
//   (IDLE/LEN/PAYLOAD/CSUM/HOLD) and the saturating-increment function; both JTAG link ends share it.
//  Sub-module jtag_dr_shift9: sr plus byte-event strobe. The rest (FSM, buffer, counters) stays flat in this module.
// TESTING
//  1. Frame A5 03 11 22 33 97
//     -> pkt_valid on the 6th update edge; pkt_len=3; pkt_data[23:0]=0x332211; upper bytes 0.
//  2. Same frame with CSUM=96
//     -> pkt_valid stays 0; err_csum=1; a following good frame is accepted.
//  3. A5 00, then A5 2D (45 > MAX_LEN)
//     -> err_len=2; FSM back in IDLE after each.
//  4. Good frame, withhold ack, send 4 more bytes
//     -> err_drop=4, pkt_data unchanged; then ack -> pkt_valid=0 next edge, busy=0.
//  5. Interleave idle words (bit8=0) and junk bytes 00 FF before SOF and between payload bytes
//     -> same packet as test 1; no counters change.
//  6. Assert jt_reset after LEN of a frame and also while in HOLD
//     -> all outputs 0 asynchronously; next full frame decodes correctly.
//  Check in all tests: counters saturate at 255 after 300 bad-LEN frames.

Source files
------------

// File: rtl/jtag_proto_pkg.sv
// Shared definitions for both ends of the JTAG user-chain link:
// the DR word layout, the framing constant, the receive FSM states and counter helpers.
package jtag_proto_pkg;

  localparam logic [7:0]  SofByte   = 8'hA5;
  localparam int unsigned WordWidth = 9;
  localparam int unsigned ValidBit  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StCsum,
    StHold
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/jtag_dr_shift9.sv
// 9-bit user DR: shifts LSB first and flags a host byte on Update-DR when the valid bit is set.
module jtag_dr_shift9
  import jtag_proto_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       sel_i,
  input  logic       capture_i,
  input  logic       shift_i,
  input  logic       update_i,
  input  logic       tdi_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);

  logic [WordWidth-1:0] sr_q;

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else if (sel_i) begin
      if (capture_i) begin
        sr_q <= '0;
      end else if (shift_i) begin
        sr_q <= {tdi_i, sr_q[WordWidth-1:1]};
      end
    end
  end

  // Combinational strobe so the consumer acts on the Update-DR edge itself.
  assign byte_valid_o = sel_i & update_i & sr_q[ValidBit];
  assign byte_o       = sr_q[7:0];

endmodule

// File: rtl/jtag_packet_rx.sv
// Host->FPGA packet receiver in the TCK domain: de-frames SOF/LEN/payload/checksum
// byte streams and holds one verified packet until the consumer acknowledges it.
module jtag_packet_rx
  import jtag_proto_pkg::*;
#(
  parameter int unsigned MAX_LEN = 44,
  parameter logic [7:0]  SOF     = SofByte
) (
  input  logic                 jt_tck,
  input  logic                 jt_reset,
  input  logic                 jt_sel,
  input  logic                 jt_capture,
  input  logic                 jt_shift,
  input  logic                 jt_update,
  input  logic                 jt_tdi,
  input  logic                 pkt_ack,
  output logic                 pkt_valid,
  output logic [7:0]           pkt_len,
  output logic [8*MAX_LEN-1:0] pkt_data,
  output logic [7:0]           err_csum,
  output logic [7:0]           err_len,
  output logic [7:0]           err_drop,
  output logic                 busy
);

  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic [7:0] csum_total;

  rx_state_e            state_q;
  logic [7:0]           len_q;
  logic [7:0]           idx_q;
  logic [7:0]           sum_q;
  logic [8*MAX_LEN-1:0] buf_q;
  logic [8*MAX_LEN-1:0] pkt_data_q;
  logic [7:0]           pkt_len_q;
  logic                 pkt_valid_q;
  logic [7:0]           err_csum_q;
  logic [7:0]           err_len_q;
  logic [7:0]           err_drop_q;

  jtag_dr_shift9 u_dr (
    .tck_i        (jt_tck),
    .rst_i        (jt_reset),
    .sel_i        (jt_sel),
    .capture_i    (jt_capture),
    .shift_i      (jt_shift),
    .update_i     (jt_update),
    .tdi_i        (jt_tdi),
    .byte_valid_o (byte_valid),
    .byte_o       (byte_data)
  );

  assign csum_total = sum_q + byte_data;

  always_ff @(posedge jt_tck or posedge jt_reset) begin
    if (jt_reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      buf_q       <= '0;
      pkt_data_q  <= '0;
      pkt_len_q   <= '0;
      pkt_valid_q <= 1'b0;
      err_csum_q  <= '0;
      err_len_q   <= '0;
      err_drop_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (byte_valid && (byte_data == SOF)) begin
            state_q <= StLen;
          end
        end
        StLen: begin
          if (byte_valid) begin
            if ((byte_data == 8'd0) || (byte_data > MaxLenB)) begin
              err_len_q <= sat_inc8(err_len_q);
              state_q   <= StIdle;
            end else begin
              len_q   <= byte_data;
              sum_q   <= byte_data;
              idx_q   <= '0;
              buf_q   <= '0;
              state_q <= StPayload;
            end
          end
        end
        StPayload: begin
          if (byte_valid) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
              if (idx_q == 8'(i)) begin
                buf_q[i*8 +: 8] <= byte_data;
              end
            end
            sum_q <= csum_total;
            idx_q <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) begin
              state_q <= StCsum;
            end
          end
        end
        StCsum: begin
          if (byte_valid) begin
            if (csum_total == 8'h00) begin
              pkt_data_q  <= buf_q;
              pkt_len_q   <= len_q;
              pkt_valid_q <= 1'b1;
              state_q     <= StHold;
            end else begin
              err_csum_q <= sat_inc8(err_csum_q);
              state_q    <= StIdle;
            end
          end
        end
        StHold: begin
          // The held packet has priority; the host must wait for the ack before sending more.
          if (byte_valid) begin
            err_drop_q <= sat_inc8(err_drop_q);
          end
          if (pkt_ack) begin
            pkt_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_data  = pkt_data_q;
  assign err_csum  = err_csum_q;
  assign err_len   = err_len_q;
  assign err_drop  = err_drop_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_jtag_packet_rx.sv
// Directed plus randomised bench for jtag_packet_rx; expected packets and error counts
// come from how each frame was constructed.
module tb_jtag_packet_rx;

  localparam int unsigned MaxLen = 44;
  localparam int unsigned DataW  = 8 * MaxLen;

  logic             jt_tck = 1'b0;
  logic             jt_reset;
  logic             jt_sel;
  logic             jt_capture;
  logic             jt_shift;
  logic             jt_update;
  logic             jt_tdi;
  logic             pkt_ack;
  logic             pkt_valid;
  logic [7:0]       pkt_len;
  logic [DataW-1:0] pkt_data;
  logic [7:0]       err_csum;
  logic [7:0]       err_len;
  logic [7:0]       err_drop;
  logic             busy;

  int n_checks = 0;
  int n_fails  = 0;
  int cnt_csum = 0;
  int cnt_len  = 0;
  int cnt_drop = 0;

  logic [7:0]       frame_q[$];
  logic [DataW-1:0] exp_data;
  logic [7:0]       exp_len;

  always #5 jt_tck = ~jt_tck;

  jtag_packet_rx #(
    .MAX_LEN (MaxLen),
    .SOF     (8'hA5)
  ) dut (
    .jt_tck     (jt_tck),
    .jt_reset   (jt_reset),
    .jt_sel     (jt_sel),
    .jt_capture (jt_capture),
    .jt_shift   (jt_shift),
    .jt_update  (jt_update),
    .jt_tdi     (jt_tdi),
    .pkt_ack    (pkt_ack),
    .pkt_valid  (pkt_valid),
    .pkt_len    (pkt_len),
    .pkt_data   (pkt_data),
    .err_csum   (err_csum),
    .err_len    (err_len),
    .err_drop   (err_drop),
    .busy       (busy)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DataW-1:0] sat(input int c);
    return (c > 255) ? DataW'(255) : DataW'(c);
  endfunction

  task automatic check(input string tag, input logic [DataW-1:0] obs,
                       input logic [DataW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_err_csum"}, DataW'(err_csum), sat(cnt_csum));
    check({tag, "_err_len"},  DataW'(err_len),  sat(cnt_len));
    check({tag, "_err_drop"}, DataW'(err_drop), sat(cnt_drop));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, DataW'(pkt_valid), '0);
    check({tag, "_len"},   DataW'(pkt_len),   '0);
    check({tag, "_data"},  pkt_data,          '0);
    check({tag, "_busy"},  DataW'(busy),      '0);
    check_counters(tag);
  endtask

  task automatic cycle();
    @(posedge jt_tck);
    #1;
  endtask

  task automatic send_word(input logic [8:0] w, input logic ack);
    jt_sel     = 1'b1;
    jt_capture = 1'b1;
    cycle();
    jt_capture = 1'b0;
    jt_shift   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      jt_tdi = w[i];
      cycle();
    end
    jt_shift  = 1'b0;
    jt_update = 1'b1;
    pkt_ack   = ack;
    cycle();
    jt_update = 1'b0;
    pkt_ack   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_word({1'b1, b}, 1'b0);
  endtask

  task automatic send_idle();
    send_word({1'b0, 8'($urandom)}, 1'b0);
  endtask

  // Good frame: checksum chosen so LEN + payload + CSUM is 0 mod 256.
  task automatic build_frame(input int len, input bit bad_csum);
    int total;
    frame_q.delete();
    exp_data = '0;
    exp_len  = 8'(len);
    total    = len;
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      frame_q.push_back(b);
      exp_data[8*i +: 8] = b;
      total += int'(b);
    end
    total = (256 - (total % 256)) % 256;
    if (bad_csum) total = (total + $urandom_range(1, 255)) % 256;
    frame_q.push_back(8'(total));
  endtask

  task automatic send_frame(input bit idle_mix);
    foreach (frame_q[i]) begin
      if (idle_mix && ($urandom_range(0, 1) == 1)) send_idle();
      send_byte(frame_q[i]);
    end
  endtask

  task automatic ack_packet(input string tag);
    pkt_ack = 1'b1;
    cycle();
    pkt_ack = 1'b0;
    check({tag, "_ack_valid"}, DataW'(pkt_valid), '0);
    check({tag, "_ack_busy"},  DataW'(busy),      '0);
  endtask

  task automatic check_packet(input string tag);
    check({tag, "_valid"}, DataW'(pkt_valid), DataW'(1));
    check({tag, "_len"},   DataW'(pkt_len),   DataW'(exp_len));
    check({tag, "_data"},  pkt_data,          exp_data);
    check_counters(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    jt_reset = 1'b1;
    #1;
    cnt_csum = 0;
    cnt_len  = 0;
    cnt_drop = 0;
    check_all_zero(tag);
    #3;
    jt_reset = 1'b0;
  endtask

  initial begin
    jt_reset   = 1'b1;
    jt_sel     = 1'b0;
    jt_capture = 1'b0;
    jt_shift   = 1'b0;
    jt_update  = 1'b0;
    jt_tdi     = 1'b0;
    pkt_ack    = 1'b0;
    repeat (3) cycle();
    check_all_zero("reset");
    jt_reset = 1'b0;
    cycle();

    // Test 1: known frame, valid only on the sixth update edge.
    frame_q  = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    exp_data = '0;
    exp_data[23:0] = 24'h332211;
    exp_len  = 8'd3;
    for (int i = 0; i < 5; i++) begin
      send_byte(frame_q[i]);
      check("t1_not_yet", DataW'(pkt_valid), '0);
    end
    send_byte(frame_q[5]);
    check_packet("t1");
    check("t1_busy", DataW'(busy), DataW'(1));
    ack_packet("t1");

    // Test 2: checksum off by one, then a good frame.
    frame_q[5] = 8'h96;
    send_frame(1'b0);
    cnt_csum++;
    check("t2_valid", DataW'(pkt_valid), '0);
    check("t2_busy", DataW'(busy), '0);
    check_counters("t2");
    build_frame(5, 1'b0);
    send_frame(1'b0);
    check_packet("t2_good");
    ack_packet("t2_good");

    // Test 3: zero and oversize LEN.
    send_byte(8'hA5);
    send_byte(8'h00);
    cnt_len++;
    check("t3_busy0", DataW'(busy), '0);
    send_byte(8'hA5);
    send_byte(8'h2D);
    cnt_len++;
    check("t3_busy45", DataW'(busy), '0);
    check_counters("t3");

    // Test 4: bytes while holding are dropped, the last one on the ack edge.
    build_frame(MaxLen, 1'b0);
    send_frame(1'b0);
    check_packet("t4_full");
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    cnt_drop += 3;
    check_packet("t4_held");
    send_word({1'b1, 8'hA5}, 1'b1);
    cnt_drop++;
    check("t4_drop", DataW'(err_drop), DataW'(4));
    check("t4_valid", DataW'(pkt_valid), '0);
    check("t4_busy", DataW'(busy), '0);

    // Test 5: idle words and junk around the frame change nothing.
    send_idle();
    send_byte(8'h00);
    send_idle();
    send_byte(8'hFF);
    frame_q  = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    exp_data = '0;
    exp_data[23:0] = 24'h332211;
    exp_len  = 8'd3;
    send_frame(1'b1);
    check_packet("t5");
    ack_packet("t5");

    // Test 6: reset mid-frame and while holding.
    send_byte(8'hA5);
    send_byte(8'h03);
    pulse_reset("t6_mid");
    build_frame(7, 1'b0);
    send_frame(1'b0);
    check_packet("t6_after_mid");
    pulse_reset("t6_hold");
    build_frame(1, 1'b0);
    send_frame(1'b0);
    check_packet("t6_after_hold");
    ack_packet("t6_after_hold");

    // Random mix of good, bad-checksum and bad-length frames.
    for (int k = 0; k < 24; k++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        build_frame($urandom_range(1, MaxLen), 1'b0);
        send_frame(1'b1);
        check_packet("rnd_good");
        for (int d = 0; d < int'($urandom_range(0, 2)); d++) begin
          send_byte(8'($urandom));
          cnt_drop++;
        end
        if ($urandom_range(0, 1) == 1) begin
          send_word({1'b1, 8'($urandom)}, 1'b1);
          cnt_drop++;
        end else begin
          ack_packet("rnd_good");
        end
        check("rnd_good_released", DataW'(pkt_valid), '0);
      end else if (kind == 2) begin
        build_frame($urandom_range(1, MaxLen), 1'b1);
        send_frame(1'b1);
        cnt_csum++;
        check("rnd_csum_valid", DataW'(pkt_valid), '0);
      end else begin
        send_byte(8'hA5);
        if ($urandom_range(0, 1) == 1) send_byte(8'h00);
        else send_byte(8'($urandom_range(MaxLen + 1, 255)));
        cnt_len++;
        check("rnd_len_busy", DataW'(busy), '0);
      end
      check_counters("rnd");
    end

    // Saturation: 300 bad-LEN frames.
    for (int k = 0; k < 300; k++) begin
      send_byte(8'hA5);
      send_byte((k % 2 == 0) ? 8'h00 : 8'hFF);
      cnt_len++;
      if (k % 60 == 59) check_counters("sat_step");
    end
    check("sat_err_len", DataW'(err_len), DataW'(255));
    build_frame(3, 1'b0);
    send_frame(1'b0);
    check_packet("sat_good");
    ack_packet("sat_good");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
